// File: rtl/datapath_gen_pkg.sv
// Shared definitions for the bus datapath.
// Holds the parameter defaults, the bus-source identifiers that the bus
// multiplexer selects between, and the memory-read controller state encoding.
package datapath_gen_pkg;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_NUM_GPR     = 16;
    localparam int DEF_IMM_BITS    = 18;
    localparam int DEF_MEM_TIMEOUT = 15;

    // Bus source identifiers; SRC_GPR is qualified by a separate GPR index.
    typedef enum logic [3:0] {
        SRC_NONE,
        SRC_GPR,
        SRC_PC,
        SRC_HI,
        SRC_LO,
        SRC_ZHI,
        SRC_ZLO,
        SRC_MDR,
        SRC_INPORT,
        SRC_C
    } bus_src_e;

    typedef enum logic {
        MEM_IDLE,
        MEM_WAIT
    } mem_state_e;

endpackage

// File: rtl/gen_register.sv
// Generic storage register with load enable and synchronous active-high clear.
// Ports: clk, clr (sync clear, dominates en), en (load d on the rising edge),
//        d (next value), q (current contents).
module gen_register #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] reg_q;
    logic [WIDTH-1:0] reg_d;

    always_comb begin
        reg_d = en ? d : reg_q;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            reg_q <= '0;
        end else begin
            reg_q <= reg_d;
        end
    end

    assign q = reg_q;

endmodule

// File: rtl/bus_datapath_gen.sv
// Single-bus CPU datapath: GPR file, PC, IR, Y, Z (HI/LO halves), HI, LO,
// MAR and MDR around one shared bus, plus a memory-read controller that
// fills MDR from an external memory with a bounded wait.
// Ports:
//   clk, clr                  clock, synchronous active-high reset
//   gpr_in / gpr_out          per-GPR load / bus-drive enables
//   pc_in, pc_inc, ir_in, y_in, z_in, hi_in, lo_in, mar_in, mdr_in, read
//                             load enables (read selects memory fill for MDR)
//   pc_out .. c_out           remaining bus-drive enables
//   inport_data, alu_result   external input port and ALU result
//   mem_data, mem_ack         memory response
//   mem_req, mem_addr         memory request and address (MAR)
//   bus_q, y_q, ir_q, pc_q    bus value and register contents
//   mem_busy, mem_done, mem_err, bus_conflict, bus_err   status flags
module bus_datapath_gen
    import datapath_gen_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int NUM_GPR     = DEF_NUM_GPR,
    parameter int IMM_BITS    = DEF_IMM_BITS,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [NUM_GPR-1:0]   gpr_in,
    input  logic [NUM_GPR-1:0]   gpr_out,
    input  logic                 pc_in,
    input  logic                 pc_inc,
    input  logic                 ir_in,
    input  logic                 y_in,
    input  logic                 z_in,
    input  logic                 hi_in,
    input  logic                 lo_in,
    input  logic                 mar_in,
    input  logic                 mdr_in,
    input  logic                 pc_out,
    input  logic                 hi_out,
    input  logic                 lo_out,
    input  logic                 zhi_out,
    input  logic                 zlo_out,
    input  logic                 mdr_out,
    input  logic                 inport_out,
    input  logic                 c_out,
    input  logic                 read,
    input  logic [WIDTH-1:0]     inport_data,
    input  logic [2*WIDTH-1:0]   alu_result,
    input  logic [WIDTH-1:0]     mem_data,
    input  logic                 mem_ack,
    output logic                 mem_req,
    output logic [WIDTH-1:0]     mem_addr,
    output logic [WIDTH-1:0]     bus_q,
    output logic [WIDTH-1:0]     y_q,
    output logic [WIDTH-1:0]     ir_q,
    output logic [WIDTH-1:0]     pc_q,
    output logic                 mem_busy,
    output logic                 mem_done,
    output logic                 mem_err,
    output logic                 bus_conflict,
    output logic                 bus_err
);

    localparam int GSEL_W = (NUM_GPR > 1) ? $clog2(NUM_GPR) : 1;
    localparam int CNT_W  = $clog2(MEM_TIMEOUT + 1);

    logic [WIDTH-1:0] gpr_q [NUM_GPR];
    logic [WIDTH-1:0] hi_q, lo_q, zhi_q, zlo_q, mar_q, mdr_q;
    logic [WIDTH-1:0] c_val;
    logic [WIDTH-1:0] pc_d, mdr_d;
    logic             pc_en, mdr_en;

    bus_src_e          src_sel;
    logic [GSEL_W-1:0] gpr_sel;
    logic [5:0]        drv_cnt;

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_done_q, mem_done_d;
    logic             mem_err_q, mem_err_d;
    logic             bus_err_q, bus_err_d;

    // Immediate constant: low IMM_BITS of IR, sign-extended.
    assign c_val = {{(WIDTH-IMM_BITS){ir_q[IMM_BITS-1]}}, ir_q[IMM_BITS-1:0]};

    // Source selection: assignments run lowest priority first so the last
    // match (gpr_out[0] ultimately) wins.
    always_comb begin
        src_sel = SRC_NONE;
        gpr_sel = '0;
        if (c_out)      src_sel = SRC_C;
        if (inport_out) src_sel = SRC_INPORT;
        if (mdr_out)    src_sel = SRC_MDR;
        if (zlo_out)    src_sel = SRC_ZLO;
        if (zhi_out)    src_sel = SRC_ZHI;
        if (lo_out)     src_sel = SRC_LO;
        if (hi_out)     src_sel = SRC_HI;
        if (pc_out)     src_sel = SRC_PC;
        for (int i = NUM_GPR - 1; i >= 0; i--) begin
            if (gpr_out[i]) begin
                src_sel = SRC_GPR;
                gpr_sel = GSEL_W'(i);
            end
        end
    end

    always_comb begin
        drv_cnt = 6'(pc_out) + 6'(hi_out) + 6'(lo_out) + 6'(zhi_out)
                + 6'(zlo_out) + 6'(mdr_out) + 6'(inport_out) + 6'(c_out);
        for (int i = 0; i < NUM_GPR; i++) begin
            drv_cnt = drv_cnt + 6'(gpr_out[i]);
        end
    end

    assign bus_conflict = (drv_cnt > 6'd1);

    // Bus is driven only from register outputs, so a register loading while
    // it drives simply re-captures its old value.
    always_comb begin
        case (src_sel)
            SRC_GPR:    bus_q = gpr_q[gpr_sel];
            SRC_PC:     bus_q = pc_q;
            SRC_HI:     bus_q = hi_q;
            SRC_LO:     bus_q = lo_q;
            SRC_ZHI:    bus_q = zhi_q;
            SRC_ZLO:    bus_q = zlo_q;
            SRC_MDR:    bus_q = mdr_q;
            SRC_INPORT: bus_q = inport_data;
            SRC_C:      bus_q = c_val;
            default:    bus_q = '0;
        endcase
    end

    // pc_in has precedence over pc_inc.
    always_comb begin
        pc_en = pc_in | pc_inc;
        pc_d  = pc_in ? bus_q : (pc_q + WIDTH'(1));
    end

    // Memory read controller: a bus-load of MDR completes in IDLE; a read
    // parks in WAIT until mem_ack or MEM_TIMEOUT WAIT cycles elapse. The
    // acknowledge is tested before the timeout so a coincident ack succeeds.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_req_d  = mem_req_q;
        mem_done_d = 1'b0;
        mem_err_d  = 1'b0;
        mdr_en     = 1'b0;
        mdr_d      = bus_q;
        bus_err_d  = bus_err_q | bus_conflict;
        case (state_q)
            MEM_IDLE: begin
                if (mdr_in) begin
                    if (read) begin
                        state_d   = MEM_WAIT;
                        cnt_d     = '0;
                        mem_req_d = 1'b1;
                    end else begin
                        mdr_en = 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    mdr_en     = 1'b1;
                    mdr_d      = mem_data;
                    state_d    = MEM_IDLE;
                    mem_req_d  = 1'b0;
                    mem_done_d = 1'b1;
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    state_d   = MEM_IDLE;
                    mem_req_d = 1'b0;
                    mem_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = MEM_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= MEM_IDLE;
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_done_q <= 1'b0;
            mem_err_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_req_q  <= mem_req_d;
            mem_done_q <= mem_done_d;
            mem_err_q  <= mem_err_d;
            bus_err_q  <= bus_err_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_GPR; g++) begin : g_gpr
            gen_register #(.WIDTH(WIDTH)) u_gpr (
                .clk (clk), .clr (clr), .en (gpr_in[g]), .d (bus_q), .q (gpr_q[g])
            );
        end
    endgenerate

    gen_register #(.WIDTH(WIDTH)) u_pc  (.clk(clk), .clr(clr), .en(pc_en),  .d(pc_d),  .q(pc_q));
    gen_register #(.WIDTH(WIDTH)) u_ir  (.clk(clk), .clr(clr), .en(ir_in),  .d(bus_q), .q(ir_q));
    gen_register #(.WIDTH(WIDTH)) u_y   (.clk(clk), .clr(clr), .en(y_in),   .d(bus_q), .q(y_q));
    gen_register #(.WIDTH(WIDTH)) u_hi  (.clk(clk), .clr(clr), .en(hi_in),  .d(bus_q), .q(hi_q));
    gen_register #(.WIDTH(WIDTH)) u_lo  (.clk(clk), .clr(clr), .en(lo_in),  .d(bus_q), .q(lo_q));
    gen_register #(.WIDTH(WIDTH)) u_mar (.clk(clk), .clr(clr), .en(mar_in), .d(bus_q), .q(mar_q));
    gen_register #(.WIDTH(WIDTH)) u_mdr (.clk(clk), .clr(clr), .en(mdr_en), .d(mdr_d), .q(mdr_q));
    gen_register #(.WIDTH(WIDTH)) u_zhi (.clk(clk), .clr(clr), .en(z_in),
                                         .d(alu_result[2*WIDTH-1:WIDTH]), .q(zhi_q));
    gen_register #(.WIDTH(WIDTH)) u_zlo (.clk(clk), .clr(clr), .en(z_in),
                                         .d(alu_result[WIDTH-1:0]), .q(zlo_q));

    assign mem_req  = mem_req_q;
    assign mem_addr = mar_q;
    assign mem_busy = (state_q == MEM_WAIT);
    assign mem_done = mem_done_q;
    assign mem_err  = mem_err_q;
    assign bus_err  = bus_err_q;

endmodule

// File: doc/bus_datapath_gen.md
BUS_DATAPATH_GEN -- requirements
Module: bus_datapath_gen

Interface
REQ-001 Parameter WIDTH, default 32, datapath word width.
REQ-002 Parameter NUM_GPR, default 16, general-purpose register count (2..32).
REQ-003 Parameter IMM_BITS, default 18, immediate field width in IR (IMM_BITS < WIDTH).
REQ-004 Parameter MEM_TIMEOUT, default 15, maximum cycles spent waiting for mem_ack.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 clr  input  1  reset, synchronous, active-high.
REQ-007 gpr_in / gpr_out  input  NUM_GPR each  per-register bus-load enables and bus-drive enables.
REQ-008 pc_in, pc_inc, ir_in, y_in, z_in, hi_in, lo_in, mar_in, mdr_in  input  1 each  load enables.
REQ-009 pc_out, hi_out, lo_out, zhi_out, zlo_out, mdr_out, inport_out, c_out  input  1 each  bus-drive enables.
REQ-010 read  input  1  with mdr_in, request memory read instead of a bus load.
REQ-011 inport_data  input  WIDTH  external input-port value.
REQ-012 alu_result  input  2*WIDTH  ALU result captured into Z.
REQ-013 mem_data  input  WIDTH; mem_ack  input  1  memory read data and acknowledge.
REQ-014 mem_req  output  1; mem_addr  output  WIDTH  registered read request and address (equals MAR).
REQ-015 bus_q, y_q, ir_q, pc_q  output  WIDTH  current bus value and register contents for ALU/control.
REQ-016 mem_busy, mem_done, mem_err, bus_conflict, bus_err  output  1 each  status flags.

Function
REQ-017 Bus source SHALL be chosen by fixed priority: gpr_out[0] highest, up through gpr_out[NUM_GPR-1], then pc, hi, lo, zhi, zlo, mdr, inport, c (lowest).
REQ-018 With no drive enable asserted bus_q SHALL be 0.
REQ-019 bus_conflict SHALL be combinationally 1 whenever two or more drive enables are asserted; bus_err SHALL be set on the next edge and remain 1 until clr.
REQ-020 The c source SHALL be ir_q[IMM_BITS-1:0] sign-extended to WIDTH.
REQ-021 Each GPR, IR, Y, HI, LO, MAR SHALL load bus_q on the edge when its enable is 1, else hold; GPR0 is an ordinary register.
REQ-022 PC: pc_in loads bus_q; else pc_inc adds 1 modulo 2^WIDTH (all-ones wraps to 0); pc_in wins when both are set.
REQ-023 z_in SHALL load alu_result[2*WIDTH-1:WIDTH] into ZHI and alu_result[WIDTH-1:0] into ZLO in one edge.
REQ-024 mdr_in with read=0 in IDLE SHALL load bus_q into MDR in one cycle.
REQ-025 Memory FSM states IDLE, WAIT; mdr_in with read=1 in IDLE SHALL go to WAIT, assert mem_req from the next cycle, clear the timeout counter.
REQ-026 In WAIT, mem_ack=1 SHALL load mem_data into MDR, return to IDLE, drop mem_req and pulse mem_done for exactly one cycle.
REQ-027 In WAIT, after MEM_TIMEOUT cycles without mem_ack the FSM SHALL return to IDLE, drop mem_req, pulse mem_err one cycle, leave MDR unchanged.
REQ-028 mem_busy SHALL equal (state==WAIT); mdr_in of either kind during WAIT SHALL be ignored.
REQ-029 mem_ack in IDLE SHALL be ignored; mem_ack coinciding with the timeout cycle SHALL count as success.
REQ-030 A register that is both driving and loading in the same cycle SHALL load its own old value (no combinational loop).

Reset
REQ-031 clr=1 at an edge SHALL zero every register (GPRs, PC, IR, Y, ZHI, ZLO, HI, LO, MAR, MDR), set FSM IDLE, and clear mem_req, mem_done, mem_err, bus_err, counter.
REQ-032 clr during WAIT SHALL abort the read; mem_req SHALL be 0 from the following cycle; a later mem_ack SHALL be ignored.
REQ-033 clr SHALL take priority over every load enable in the same cycle.

Structure
REQ-034 Shared package datapath_gen_pkg SHALL hold the bus-source index enum, memory FSM state enum and parameter defaults.
REQ-035 One sub-module gen_register (WIDTH-parametrised, enable, synchronous clr) SHALL be instantiated for every storage register.

Verification
REQ-036 gpr_in[3]=1, inport_out=1, inport_data=0x12345678 -> R3=0x12345678 next cycle; gpr_out[3] alone -> bus_q=0x12345678.
REQ-037 gpr_out[2]=1 and pc_out=1 together -> bus_q=R2, bus_conflict=1, bus_err=1 from next cycle until clr.
REQ-038 IR=0x0003FFFF, c_out=1 -> bus_q=0xFFFFFFFF; IR=0x0001FFFF -> bus_q=0x0001FFFF.
REQ-039 MAR=0x40, mdr_in=read=1, mem_ack after 3 cycles with mem_data=0xCAFEF00D -> mem_addr=0x40, MDR=0xCAFEF00D, one mem_done pulse.
REQ-040 Read with no ack -> mem_err pulse after 15 WAIT cycles, MDR unchanged; repeat with clr mid-WAIT -> mem_req 0 next cycle, MDR=0.
REQ-041 PC=0xFFFFFFFF, pc_inc=1 -> PC=0; pc_in and pc_inc together with bus 0x100 -> PC=0x100.
